// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches ahead of decode and buffers {pc, inst}.
// Kept response is visible one cycle after its edge; issue stalls once buffered + in-flight reaches DEPTH.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] out_inst
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam logic [CW:0] DEPTH_R = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  cnt_t          count_q, count_d;
  cnt_t          inflight_q, inflight_d;
  cnt_t          drop_q, drop_d;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic [CW:0]   reserved;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          head_vld;
  logic [31:0]   head_pc;

  // Slots are reserved at issue time, so a kept response always has room.
  assign reserved       = {1'b0, count_q} + {1'b0, inflight_q};
  assign imem_req_valid = rst && !redirect_valid && (reserved < DEPTH_R);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push     = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign head_vld = (count_q != '0);
  assign head_pc  = pc_mem[rd_ptr_q];

  assign out_valid    = head_vld && !redirect_valid;
  assign out_pc       = head_vld ? head_pc : '0;
  assign out_pc_plus4 = head_vld ? head_pc + 32'd4 : '0;
  assign out_inst     = head_vld ? inst_mem[rd_ptr_q] : '0;
  assign pop          = out_valid && out_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;

    if (redirect_valid) begin
      // Everything still outstanding belongs to the old path; a response landing now is dropped too.
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = inflight_q - cnt_t'(imem_rsp_valid);
      drop_d     = inflight_q - cnt_t'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - cnt_t'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Entry storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
      inst_mem[wr_ptr_q] <= imem_rsp_inst;
    end
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction prefetch queue between instruction memory and the IF/ID pipeline register. It issues sequential fetch requests ahead of decode to a valid/ready instruction-memory port and buffers returned instructions with their PC. It presents {pc, pc+4, inst} to IF/ID through a valid/ready handshake. On a branch or jump redirect from ID it flushes all buffered and in-flight instructions and restarts fetch at the target.

## Interface
Parameters:
- DEPTH, 4: queue entries; also the maximum number of outstanding memory requests (power of two, ≥2).
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. While low, all state is at its reset value.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  fetch address, word-aligned.
- imem_rsp_valid  in  1  response valid. Responses return in request order, at least 1 cycle after acceptance.
- imem_rsp_inst  in  32  fetched instruction.
- redirect_valid  in  1  flush and restart fetch (PCSel taken in ID).
- redirect_pc  in  32  restart address.
- out_valid  out  1  head entry valid toward IF/ID.
- out_ready  in  1  IF/ID accepts the head entry (not stalled).
- out_pc, out_pc_plus4, out_inst  out  32 each  head entry contents.

## Operation
- State:
  - fetch_pc: next address to issue.
  - rsp_pc: PC of the next kept response.
  - Circular FIFO of {pc, inst} with rd/wr pointers and count (0..DEPTH).
  - inflight: accepted requests without a response (0..DEPTH).
  - drop_cnt: stale responses still to be discarded (≤ inflight).
- Issue rule: imem_req_valid = !redirect_valid && (count + inflight < DEPTH). imem_req_addr = fetch_pc.
  - On imem_req_valid && imem_req_ready: fetch_pc += 4 (32-bit wrap) and inflight += 1.
  - Space is reserved at issue time, so the FIFO can never overflow.
- Response rule: on imem_rsp_valid, inflight -= 1.
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise: push {rsp_pc, imem_rsp_inst} and rsp_pc += 4.
- Output rule:
  - out_valid = (count != 0) && !redirect_valid.
  - out_pc and out_inst come from the head entry; out_pc_plus4 = out_pc + 4.
  - When count == 0, all three are 0.
  - Pop on out_valid && out_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance. A push into an empty FIFO is not bypassed.
- Redirect (highest priority), on the clock edge:
  - count = 0 and pointers reset.
  - fetch_pc = rsp_pc = redirect_pc.
  - drop_cnt = inflight − imem_rsp_valid. A response arriving in the redirect cycle is itself discarded.
  - inflight = inflight − imem_rsp_valid.
  - No request is issued and no pop occurs in the redirect cycle.
- Redirect while drop_cnt > 0: the same rule applies; all outstanding requests are stale.
- redirect_pc is used as given. Low bits are not masked.

## Timing
- Reset values:
  - imem_req_valid = 1 after reset release; 0 while rst is low.
  - imem_req_addr = RESET_PC.
  - out_valid = 0; out_pc = out_inst = out_pc_plus4 = 0.
  - count = inflight = drop_cnt = 0.
- Latency: a response kept at edge N is visible as out_valid/out_inst in the cycle after edge N.
- Throughput: with a 1-cycle memory and out_ready held high, one instruction per cycle in steady state.
- Redirect to first new out_valid: redirect edge R, request issued in cycle R+1, response at R+1+L (L = memory latency), out_valid from the next cycle.
- Reset asserted mid-operation clears everything immediately. Responses still in flight from before reset are the memory's responsibility, since the memory shares the reset.

## Test plan
- Reset and stream: RESET_PC=0, 1-cycle memory returning inst=addr|0x13, out_ready=1 → out sequence pc=0,4,8,… with out_pc_plus4=pc+4 and one entry per cycle from the 3rd cycle after reset release.
- Backpressure: out_ready=0 for 10 cycles → count reaches 4, imem_req_valid=0 once count+inflight=4. Then out_ready=1 → pcs 0,4,8,12,16 delivered in order with no loss or duplicate.
- Redirect with in-flight requests: 3-cycle memory with 3 requests outstanding, redirect_pc=0x100 → the 3 stale responses are dropped and the next out_pc=0x100, then 0x104.
- Redirect coincident with a response and a pop: redirect_valid=1 with imem_rsp_valid=1 and out_ready=1 → out_valid=0 that cycle, the response is discarded, and the first output afterwards is pc=0x100.
- Back-to-back redirects: redirect to 0x40, then to 0x80 the next cycle → no instruction from 0x40 ever appears; the first out_pc is 0x80.
- Async reset mid-stream: rst low between clock edges → out_valid=0 and imem_req_addr=RESET_PC immediately. After release the fetch stream restarts at RESET_PC.
